// File: rtl/mips_pkg.sv
// Shared MIPS definitions: multiply/divide op encodings and the mul/div FSM states.
package mips_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_FIX  = 2'b10
    } md_state_e;

    function automatic logic op_is_div(input md_op_e op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic op_is_signed(input md_op_e op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

endpackage

// File: rtl/md_step.sv
// One radix-2 iteration: MSB-first shift-add multiply or restoring divide step.
module md_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 is_div,
    input  logic [2*WIDTH-1:0]   acc,
    input  logic                 in_bit,
    input  logic [WIDTH-1:0]     operand,
    output logic [2*WIDTH-1:0]   acc_next,
    output logic                 qbit
);

    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] diff;

    always_comb begin
        rem_sh   = {acc[WIDTH-1:0], in_bit};
        diff     = rem_sh - {1'b0, operand};
        acc_next = '0;
        qbit     = 1'b0;
        if (is_div) begin
            // Remainder lives in acc[WIDTH:0]; the next dividend bit shifts in at the bottom.
            if (rem_sh >= {1'b0, operand}) begin
                acc_next[WIDTH:0] = diff;
                qbit              = 1'b1;
            end else begin
                acc_next[WIDTH:0] = rem_sh;
            end
        end else begin
            acc_next = {acc[2*WIDTH-2:0], 1'b0}
                     + (in_bit ? {{WIDTH{1'b0}}, operand} : {(2*WIDTH){1'b0}});
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative mult/multu/div/divu unit owning HI/LO; WIDTH steps plus one sign-fix cycle.
module mul_div_unit
    import mips_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       MDConf,
    input  logic [WIDTH-1:0] In1,
    input  logic [WIDTH-1:0] In2,
    input  logic             HiWrite,
    input  logic             LoWrite,
    input  logic [WIDTH-1:0] WriteData,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    md_state_e          state, state_nx;
    md_op_e             op;
    logic [CW-1:0]      counter;
    logic [2*WIDTH-1:0] acc, acc_step;
    logic [WIDTH-1:0]   q, opnd;
    logic               is_div, neg_res, neg_rem, div_zero, qbit;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   mag1, mag2;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo, rem;

    assign op   = md_op_e'(MDConf);
    assign busy = (state != S_IDLE);

    always_comb begin
        a_neg = op_is_signed(op) & In1[WIDTH-1];
        b_neg = op_is_signed(op) & In2[WIDTH-1];
        mag1  = a_neg ? -In1 : In1;
        mag2  = b_neg ? -In2 : In2;
    end

    md_step #(.WIDTH(WIDTH)) u_step (
        .is_div   (is_div),
        .acc      (acc),
        .in_bit   (q[WIDTH-1]),
        .operand  (opnd),
        .acc_next (acc_step),
        .qbit     (qbit)
    );

    // A zero divisor yields an all-ones quotient magnitude; force Lo to all ones
    // so the sign fix cannot disturb it. The remainder already equals the dividend.
    always_comb begin
        prod = neg_res ? -acc : acc;
        quo  = div_zero ? '1 : (neg_res ? -q : q);
        rem  = neg_rem ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = S_CALC;
            S_CALC:  if (counter == LAST) state_nx = S_FIX;
            S_FIX:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            counter  <= '0;
            acc      <= '0;
            q        <= '0;
            opnd     <= '0;
            is_div   <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            done     <= 1'b0;
            Hi       <= '0;
            Lo       <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (HiWrite) Hi <= WriteData;
                    if (LoWrite) Lo <= WriteData;
                    if (start) begin
                        counter  <= '0;
                        acc      <= '0;
                        is_div   <= op_is_div(op);
                        neg_res  <= a_neg ^ b_neg;
                        neg_rem  <= a_neg;
                        div_zero <= op_is_div(op) && (In2 == '0);
                        if (op_is_div(op)) begin
                            q    <= mag1;
                            opnd <= mag2;
                        end else begin
                            q    <= mag2;
                            opnd <= mag1;
                        end
                    end
                end
                S_CALC: begin
                    acc     <= acc_step;
                    q       <= {q[WIDTH-2:0], qbit};
                    counter <= counter + CW'(1);
                end
                S_FIX: begin
                    done <= 1'b1;
                    if (is_div) begin
                        Hi <= rem;
                        Lo <= quo;
                    end else begin
                        Hi <= prod[2*WIDTH-1:WIDTH];
                        Lo <= prod[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
